// File: rtl/pot_paddle_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pot_paddle_responder_pkg
//  Brief   : Shared POKEY IO pot-scan definitions (states, scan timing).
//  Rev     : 1.0  initial release
// ============================================================================
package pot_paddle_responder_pkg;

    typedef enum logic [1:0] {
        POT_IDLE   = 2'd0,
        POT_DUMP   = 2'd1,
        POT_CHARGE = 2'd2
    } pot_state_e;

    localparam int POT_DUMP_CYCLES = 17;
    localparam int POT_MIN_COUNT   = 5;
    localparam int POT_MAX_COUNT   = 228;

    // The scanner cannot report a count below its blanking window.
    function automatic logic [7:0] pot_target(input logic [7:0] pos,
                                              input logic [7:0] min_count);
        return (pos < min_count) ? min_count : pos;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pot_paddle_responder_if.sv
`default_nettype none
// ============================================================================
//  Module  : pot_paddle_responder_if
//  Brief   : POTGO request, paddle positions and pot line bundle.
//  Rev     : 1.0  initial release
// ============================================================================
interface pot_paddle_responder_if #(
    parameter int NUM_POTS = 8
);
    logic                    POTGO;
    logic [8*NUM_POTS-1:0]   pot_pos;
    logic [NUM_POTS-1:0]     pot_connected;
    logic [NUM_POTS-1:0]     pot_line;
    logic                    scan_active;
    logic                    scan_done;

    modport master (
        output POTGO, pot_pos, pot_connected,
        input  pot_line, scan_active, scan_done
    );

    modport slave (
        input  POTGO, pot_pos, pot_connected,
        output pot_line, scan_active, scan_done
    );
endinterface
`default_nettype wire

// File: rtl/pot_channel_cmp.sv
`default_nettype none
// ============================================================================
//  Module  : pot_channel_cmp
//  Brief   : One pot channel: position snapshot, clamped target, line register.
//  Rev     : 1.0  initial release
// ============================================================================
module pot_channel_cmp
    import pot_paddle_responder_pkg::*;
#(
    parameter int MIN_COUNT = POT_MIN_COUNT,
    parameter int MAX_COUNT = POT_MAX_COUNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_snap,
    input  logic [7:0] i_pos,
    input  logic       i_connected,
    input  pot_state_e i_next_state,
    input  logic [7:0] i_next_cnt,
    output logic       o_line
);
    localparam logic [7:0] C_MIN_COUNT = 8'(MIN_COUNT);
    localparam logic [7:0] C_MAX_COUNT = 8'(MAX_COUNT);

    logic [7:0] r_pos_snap;
    logic [7:0] w_target;
    logic       w_reachable;
    logic       w_line_next;

    // Line is computed against the next count so it is high in the very
    // cycle the shared counter equals the target.
    always_comb begin
        w_target    = pot_target(r_pos_snap, C_MIN_COUNT);
        w_reachable = i_connected && (w_target < C_MAX_COUNT);
        w_line_next = 1'b1;
        case (i_next_state)
            POT_IDLE:   w_line_next = 1'b1;
            POT_DUMP:   w_line_next = 1'b0;
            POT_CHARGE: w_line_next = w_reachable && (i_next_cnt >= w_target);
            default:    w_line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_snap <= '0;
            o_line     <= 1'b1;
        end else begin
            if (i_snap) begin
                r_pos_snap <= i_pos;
            end
            o_line <= w_line_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/pot_paddle_responder.sv
`default_nettype none
// ============================================================================
//  Module  : pot_paddle_responder
//  Brief   : Paddle model answering POKEY pot scans: dump on POTGO, then
//            raise each pot line after a count equal to its position.
//  Rev     : 1.0  initial release
// ============================================================================
module pot_paddle_responder
    import pot_paddle_responder_pkg::*;
#(
    parameter int NUM_POTS    = 8,
    parameter int DUMP_CYCLES = POT_DUMP_CYCLES,
    parameter int MIN_COUNT   = POT_MIN_COUNT,
    parameter int MAX_COUNT   = POT_MAX_COUNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pot_paddle_responder_if.slave bus
);
    localparam logic [7:0] C_DUMP_CYCLES = 8'(DUMP_CYCLES);
    localparam logic [7:0] C_MAX_COUNT   = 8'(MAX_COUNT);
    localparam logic [7:0] C_CNT_SAT     = 8'hFF;

    pot_state_e          r_state;
    pot_state_e          w_state_next;
    logic [7:0]          r_dump_cnt;
    logic [7:0]          w_dump_cnt_next;
    logic [7:0]          r_chg_cnt;
    logic [7:0]          w_chg_cnt_next;
    logic                w_snap;
    logic                w_exit;
    logic                w_all_charged;
    logic [NUM_POTS-1:0] w_lines;

    // With nothing connected the scan must run to the scanner timeout.
    assign w_all_charged = (bus.pot_connected != '0) &&
                           ((w_lines | ~bus.pot_connected) == '1);

    always_comb begin
        w_state_next    = r_state;
        w_dump_cnt_next = r_dump_cnt;
        w_chg_cnt_next  = r_chg_cnt;
        w_snap          = 1'b0;
        w_exit          = 1'b0;
        case (r_state)
            POT_IDLE: begin
                w_dump_cnt_next = '0;
                if (bus.POTGO) begin
                    w_state_next    = POT_DUMP;
                    w_dump_cnt_next = 8'd1;
                end
            end
            POT_DUMP: begin
                if (!bus.POTGO) begin
                    w_state_next    = POT_IDLE;
                    w_dump_cnt_next = '0;
                end else if (r_dump_cnt == C_DUMP_CYCLES) begin
                    w_state_next    = POT_CHARGE;
                    w_dump_cnt_next = '0;
                    w_chg_cnt_next  = '0;
                    w_snap          = 1'b1;
                end else begin
                    w_dump_cnt_next = r_dump_cnt + 8'd1;
                end
            end
            POT_CHARGE: begin
                w_chg_cnt_next = (r_chg_cnt == C_CNT_SAT) ? r_chg_cnt : r_chg_cnt + 8'd1;
                if ((r_chg_cnt == C_MAX_COUNT) || w_all_charged) begin
                    w_state_next = POT_IDLE;
                    w_exit       = 1'b1;
                end
            end
            default: begin
                w_state_next = POT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= POT_IDLE;
            r_dump_cnt <= '0;
            r_chg_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_dump_cnt <= w_dump_cnt_next;
            r_chg_cnt  <= w_chg_cnt_next;
        end
    end

    generate
        for (genvar i = 0; i < NUM_POTS; i++) begin : g_chan
            pot_channel_cmp #(
                .MIN_COUNT (MIN_COUNT),
                .MAX_COUNT (MAX_COUNT)
            ) u_cmp (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_snap       (w_snap),
                .i_pos        (bus.pot_pos[8*i +: 8]),
                .i_connected  (bus.pot_connected[i]),
                .i_next_state (w_state_next),
                .i_next_cnt   (w_chg_cnt_next),
                .o_line       (w_lines[i])
            );
        end
    endgenerate

    assign bus.pot_line    = w_lines;
    assign bus.scan_active = (r_state != POT_IDLE);
    assign bus.scan_done   = w_exit;
endmodule
`default_nettype wire

// File: tb/tb_pot_paddle_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pot_paddle_responder
//  Brief   : Scoreboard bench for the pot paddle responder.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pot_paddle_responder;
    localparam int N         = 8;
    localparam int DUMP      = 17;
    localparam int CHG_START = DUMP + 1;
    localparam int MINC      = 5;
    localparam int MAXC      = 228;

    typedef struct packed {
        int                   done;
        logic [N-1:0][31:0]   rise;
        logic [N-1:0]         fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    pot_paddle_responder_if #(.NUM_POTS(N)) bus ();

    pot_paddle_responder #(.NUM_POTS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name,
                     $signed(act), $signed(req), cyc);
        end
    endfunction

    function automatic logic [N-1:0] conn_at(logic [N-1:0] conn, bit drop, int dk, int dd, int t);
        logic [N-1:0] r;
        r = conn;
        if (drop && t >= dd) r[dk] = 1'b0;
        return r;
    endfunction

    // Reference: a line is high at charge cycle t when its paddle was present
    // on the previous cycle, its target is reachable and t has reached it.
    function automatic exp_t model(int c, logic [N-1:0][7:0] pos, logic [N-1:0] conn,
                                   bit drop, int dk, int dd);
        exp_t e;
        int   tgt[N];
        int   r[N];
        e.done = 0;
        e.fin  = '0;
        for (int i = 0; i < N; i++) begin
            tgt[i] = (int'(pos[i]) < MINC) ? MINC : int'(pos[i]);
            r[i]   = -1;
        end
        for (int t = 0; t <= MAXC; t++) begin
            logic [N-1:0] cn, cp, ln;
            cn = conn_at(conn, drop, dk, dd, t);
            cp = (t == 0) ? '0 : conn_at(conn, drop, dk, dd, t - 1);
            for (int i = 0; i < N; i++) begin
                ln[i] = cp[i] && (tgt[i] < MAXC) && (t >= tgt[i]);
                if (ln[i] && r[i] < 0) r[i] = c + CHG_START + t;
            end
            if (t == MAXC || (cn != '0 && (ln | ~cn) == '1)) begin
                e.done = c + CHG_START + t;
                e.fin  = ln;
                break;
            end
        end
        for (int i = 0; i < N; i++) e.rise[i] = 32'(r[i]);
        return e;
    endfunction

    function automatic logic [7:0] pick_pos();
        case ($urandom_range(0, 7))
            0:       return 8'($urandom_range(0, 4));
            1:       return 8'd5;
            2:       return 8'd227;
            3:       return 8'd228;
            4:       return 8'($urandom_range(229, 255));
            default: return 8'($urandom_range(6, 226));
        endcase
    endfunction

    // Starts a scan in the current cycle; returns at the negedge of the IDLE
    // cycle that follows scan_done, with POTGO still high.
    task automatic run_scan(input logic [N-1:0][7:0] pa, input logic [N-1:0][7:0] pb,
                            input logic [N-1:0][7:0] pc, input logic [N-1:0] conn,
                            input bit drop, input int dk, input int dd);
        int   c;
        exp_t e;
        c = cyc;
        bus.POTGO         = 1'b1;
        bus.pot_pos       = pa;
        bus.pot_connected = conn;
        e = model(c, pb, conn, drop, dk, dd);
        exp_q.push_back(e);
        while (cyc < e.done + 1) begin
            @(negedge clk);
            if (cyc == c + 5) bus.pot_pos = pb;
            if (cyc == c + CHG_START + 20) bus.pot_pos = pc;
            if (drop && cyc == c + CHG_START + dd) bus.pot_connected[dk] = 1'b0;
        end
    endtask

    task automatic rand_scan();
        logic [N-1:0][7:0] pa, pb, pc;
        logic [N-1:0]      conn;
        bit                drop;
        int                dk, dd;
        for (int i = 0; i < N; i++) begin
            pa[i] = pick_pos();
            pb[i] = ($urandom_range(0, 1) == 0) ? pa[i] : pick_pos();
            pc[i] = pick_pos();
        end
        conn = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
        if ($urandom_range(0, 9) == 0) conn = '0;
        drop = ($urandom_range(0, 3) == 0);
        dk   = $urandom_range(0, N - 1);
        dd   = $urandom_range(0, 150);
        run_scan(pa, pb, pc, conn, drop, dk, dd);
    endtask

    // Monitor: record first rise per channel, score each scan on scan_done.
    int   seen[N];
    bit   chk_idle = 1'b0;
    exp_t mon_e;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) seen[i] = -1;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("idle_lines_after_scan", 32'(bus.pot_line), 32'({N{1'b1}}));
                check("idle_active_after_scan", 32'(bus.scan_active), 32'd0);
                chk_idle = 1'b0;
            end
            if (bus.scan_active) begin
                for (int i = 0; i < N; i++)
                    if (bus.pot_line[i] && seen[i] < 0) seen[i] = cyc;
            end
            if (bus.scan_done) begin
                if (exp_q.size() == 0) begin
                    check("scan_done_without_scan", 32'(bus.scan_done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("scan_done_cycle", 32'(cyc), 32'(mon_e.done));
                    for (int i = 0; i < N; i++)
                        check($sformatf("rise_cycle_ch%0d", i), 32'(seen[i]), mon_e.rise[i]);
                    check("lines_at_done", 32'(bus.pot_line), 32'(mon_e.fin));
                    chk_idle = 1'b1;
                end
                for (int i = 0; i < N; i++) seen[i] = -1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0][7:0] p, q;
        int                c;
        rst_n             = 1'b0;
        bus.POTGO         = 1'b0;
        bus.pot_pos       = '0;
        bus.pot_connected = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_lines", 32'(bus.pot_line), 32'({N{1'b1}}));
        check("reset_active", 32'(bus.scan_active), 32'd0);
        check("reset_done", 32'(bus.scan_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single channel at 100, then clamp-low and unreachable positions.
        p = '0; p[0] = 8'd100;
        run_scan(p, p, p, 8'h01, 1'b0, 0, 0);
        p[0] = 8'd2;
        run_scan(p, p, p, 8'h01, 1'b0, 0, 0);
        p[0] = 8'd240;
        run_scan(p, p, p, 8'h01, 1'b0, 0, 0);

        // Abort at dump cycle 10.
        c = cyc;
        bus.POTGO = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("dump_lines_low", 32'(bus.pot_line), 32'd0);
        check("dump_active", 32'(bus.scan_active), 32'd1);
        bus.POTGO = 1'b0;
        @(negedge clk);
        #1;
        check("abort_lines_high", 32'(bus.pot_line), 32'({N{1'b1}}));
        check("abort_inactive", 32'(bus.scan_active), 32'd0);
        repeat (3) @(negedge clk);
        rand_scan();

        // Position rewritten mid-charge; ch3 disconnected.
        for (int i = 0; i < N; i++) p[i] = 8'($urandom_range(5, 227));
        p[0] = 8'd50;
        q = p; q[0] = 8'd200;
        run_scan(p, p, q, 8'hF7, 1'b0, 0, 0);
        run_scan(q, q, q, 8'hF7, 1'b0, 0, 0);

        // Back-to-back full-population scans.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < N; i++) p[i] = 8'($urandom_range(5, 227));
            run_scan(p, p, p, '1, 1'b0, 0, 0);
        end

        for (int s = 0; s < 20; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.POTGO = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
            rand_scan();
        end

        // Asynchronous reset at charge count 60.
        bus.POTGO = 1'b0;
        repeat (2) @(negedge clk);
        c = cyc;
        for (int i = 0; i < N; i++) p[i] = 8'd150;
        bus.pot_pos       = p;
        bus.pot_connected = '1;
        bus.POTGO         = 1'b1;
        while (cyc < c + CHG_START + 60) @(negedge clk);
        #3;
        check("pre_reset_active", 32'(bus.scan_active), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_lines", 32'(bus.pot_line), 32'({N{1'b1}}));
        check("async_reset_active", 32'(bus.scan_active), 32'd0);
        check("async_reset_done", 32'(bus.scan_done), 32'd0);
        bus.POTGO = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rand_scan();
        run_scan(p, p, p, '1, 1'b0, 0, 0);

        bus.POTGO = 1'b0;
        repeat (5) @(negedge clk);
        check("pending_scans", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
